// File: rtl/leitor_pixels_fonte_pkg.sv
// Algorithm/zoom codes and FSM encoding shared by the source-pixel reader.
package leitor_pixels_fonte_pkg;

    localparam logic [3:0] ALG_NNI_ZIN  = 4'b0001;
    localparam logic [3:0] ALG_REP      = 4'b0010;
    localparam logic [3:0] ALG_NNI_ZOUT = 4'b0100;
    localparam logic [3:0] ALG_MEDIA    = 4'b1000;

    localparam logic [1:0] ZOOM_1X = 2'b00;
    localparam logic [1:0] ZOOM_2X = 2'b01;
    localparam logic [1:0] ZOOM_4X = 2'b10;

    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        LEITURA = 2'd1,
        ESPERA  = 2'd2,
        SAIDA   = 2'd3
    } estado_t;

    // log2 of the number of reads; zoom 11 falls through to the single-read case
    function automatic logic [2:0] log2_leituras(input logic [3:0] alg, input logic [1:0] zoom);
        if (alg == ALG_MEDIA && zoom == ZOOM_2X) return 3'd2;
        if (alg == ALG_MEDIA && zoom == ZOOM_4X) return 3'd4;
        return 3'd0;
    endfunction

endpackage

// File: rtl/leitor_pixels_fonte_calc_endereco.sv
// Clamps a source coordinate to the image and forms the linear RAM address.
// Purely combinational; no handshake.
module calc_endereco
    import leitor_pixels_fonte_pkg::*;
#(
    parameter int LARGURA = 320,
    parameter int ALTURA  = 240,
    parameter int ADDR_W  = 17
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic [ADDR_W-1:0]  endereco
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(LARGURA - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(ALTURA - 1);

    logic [COORD_W-1:0] xc;
    logic [COORD_W-1:0] yc;

    // LARGURA is a constant, so the multiply reduces to shifts and adds
    always_comb begin
        xc       = (x > X_MAX) ? X_MAX : x;
        yc       = (y > Y_MAX) ? Y_MAX : y;
        endereco = ADDR_W'(yc) * ADDR_W'(LARGURA) + ADDR_W'(xc);
    end

endmodule

// File: rtl/leitor_pixels_fonte.sv
// Reads 1/4/16 source pixels for one coordinate set and emits their (averaged) value.
// Latency N+RD_LAT+1 cycles from accept to out_valid; holds out_pixel while out_ready is low.
module leitor_pixels_fonte
    import leitor_pixels_fonte_pkg::*;
#(
    parameter int LARGURA = 320,
    parameter int ALTURA  = 240,
    parameter int ADDR_W  = 17,
    parameter int RD_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        algoritmo,
    input  logic [1:0]        zoom,
    input  logic [159:0]      x_fonte,
    input  logic [159:0]      y_fonte,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_pixel
);

    estado_t            estado, estado_prox;
    logic [159:0]       x_r, y_r;
    logic [2:0]         shift_r;
    logic [3:0]         rd_cnt, ret_cnt, ultimo_idx;
    logic [4:0]         n_total;
    logic [11:0]        acc, soma;
    logic [RD_LAT-1:0]  tag;
    logic               aceita, ret_vld, ultimo_ret;
    logic [COORD_W-1:0] x_par, y_par;
    logic [ADDR_W-1:0]  endereco;

    assign in_ready   = (estado == OCIOSO) && !reset;
    assign aceita     = in_valid && in_ready;
    assign mem_rd_en  = (estado == LEITURA) && !reset;
    assign mem_addr   = mem_rd_en ? endereco : '0;
    assign out_valid  = (estado == SAIDA);

    assign n_total    = 5'd1 << shift_r;
    assign ultimo_idx = 4'(n_total - 5'd1);
    assign ret_vld    = tag[RD_LAT-1];
    assign ultimo_ret = ret_vld && (ret_cnt == ultimo_idx) && (estado == ESPERA);
    assign soma       = acc + 12'(mem_rdata);

    assign x_par = x_r[8'(rd_cnt) * 8'd10 +: COORD_W];
    assign y_par = y_r[8'(rd_cnt) * 8'd10 +: COORD_W];

    calc_endereco #(
        .LARGURA (LARGURA),
        .ALTURA  (ALTURA),
        .ADDR_W  (ADDR_W)
    ) u_calc_endereco (
        .x        (x_par),
        .y        (y_par),
        .endereco (endereco)
    );

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO:  if (aceita) estado_prox = LEITURA;
            LEITURA: if (rd_cnt == ultimo_idx) estado_prox = ESPERA;
            ESPERA:  if (ultimo_ret) estado_prox = SAIDA;
            SAIDA:   if (out_ready) estado_prox = OCIOSO;
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= OCIOSO;
            x_r       <= '0;
            y_r       <= '0;
            shift_r   <= '0;
            rd_cnt    <= '0;
            ret_cnt   <= '0;
            acc       <= '0;
            out_pixel <= '0;
        end else begin
            estado <= estado_prox;
            if (aceita) begin
                x_r     <= x_fonte;
                y_r     <= y_fonte;
                shift_r <= log2_leituras(algoritmo, zoom);
                rd_cnt  <= '0;
                ret_cnt <= '0;
                acc     <= '0;
            end
            if (mem_rd_en) rd_cnt <= rd_cnt + 4'd1;
            if (ret_vld) begin
                acc     <= soma;
                ret_cnt <= ret_cnt + 4'd1;
            end
            if (ultimo_ret) out_pixel <= 8'(soma >> shift_r);
        end
    end

    // Each strobe travels RD_LAT stages so only real returns reach the accumulator
    generate
        if (RD_LAT == 1) begin : g_tag1
            always_ff @(posedge clk) begin
                if (reset) tag <= '0;
                else       tag <= mem_rd_en;
            end
        end else begin : g_tagn
            always_ff @(posedge clk) begin
                if (reset) tag <= '0;
                else       tag <= {tag[RD_LAT-2:0], mem_rd_en};
            end
        end
    endgenerate

endmodule
